// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory pipeline.
// Contents: NOP encoding returned on faulted fetches, error bit positions,
// and the response payload carried through the response buffer.
package inst_mem_pkg;

   localparam int unsigned FETCH_W = 32;
   localparam int unsigned ERR_W   = 2;

   // Canonical RV32 NOP (addi x0, x0, 0)
   localparam logic [FETCH_W-1:0] NOP_INST = 32'h0000_0013;

   localparam int unsigned ERR_MISALIGNED = 0;
   localparam int unsigned ERR_OOR        = 1;

   typedef struct packed {
      logic [FETCH_W-1:0] inst;
      logic [FETCH_W-1:0] addr;
      logic [ERR_W-1:0]   err;
   } fetch_rsp_t;

endpackage

// File: rtl/inst_mem_pipe_if.sv
// Fetch and program-load bus of the instruction memory.
// master: fetch stage / boot loader side (drives requests, flush, load).
// slave : the memory (drives req_ready_o and the rsp_* signals).
interface inst_mem_pipe_if #(
   parameter int unsigned XLEN = 32
);

   logic              req_valid_i;
   logic              req_ready_o;
   logic [XLEN-1:0]   req_addr_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [XLEN-1:0]   rsp_inst_o;
   logic [XLEN-1:0]   rsp_addr_o;
   logic [1:0]        rsp_err_o;
   logic              flush_i;
   logic              ld_en_i;
   logic [XLEN-1:0]   ld_addr_i;
   logic [XLEN-1:0]   ld_data_i;
   logic [XLEN/8-1:0] ld_be_i;

   modport master (
      output req_valid_i, req_addr_i, rsp_ready_i, flush_i,
             ld_en_i, ld_addr_i, ld_data_i, ld_be_i,
      input  req_ready_o, rsp_valid_o, rsp_inst_o, rsp_addr_o, rsp_err_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, rsp_ready_i, flush_i,
             ld_en_i, ld_addr_i, ld_data_i, ld_be_i,
      output req_ready_o, rsp_valid_o, rsp_inst_o, rsp_addr_o, rsp_err_o
   );

endinterface

// File: rtl/inst_rsp_fifo.sv
// Two-entry in-order response buffer for fetch responses.
// Ports: clk, rst (sync, active-high); push/din write side; pop consumes
// the head; flush drops every stored entry (a push in the same cycle is
// kept); dout is the head entry; full/empty status.
module inst_rsp_fifo
   import inst_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  fetch_rsp_t din,
   input  logic       pop,
   input  logic       flush,
   output fetch_rsp_t dout,
   output logic       full,
   output logic       empty
);

   localparam int unsigned CNT_W = 2;

   fetch_rsp_t       head_q, head_d;
   fetch_rsp_t       tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] kept;
   logic             do_pop;

   // Next state: drop/pop first, then append the pushed entry behind survivors
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      do_pop  = pop && (count_q != '0);
      kept    = flush ? '0 : (count_q - CNT_W'(do_pop));
      if (!flush && do_pop) begin
         head_d = tail_q;
      end
      count_d = kept;
      if (push && (kept != CNT_W'(2))) begin
         if (kept == '0) begin
            head_d = din;
         end else begin
            tail_d = din;
         end
         count_d = kept + CNT_W'(1);
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign dout  = head_q;
   assign full  = (count_q == CNT_W'(2));
   assign empty = (count_q == '0);

endmodule

// File: rtl/inst_mem_pipe.sv
// Instruction memory with valid/ready fetch port, 2-entry response buffer,
// fetch flush, byte-enabled program-load port and fault reporting.
// Ports: clk; rst (sync, active-high); bus (slave modport) carrying
//   req_valid_i/req_ready_o/req_addr_i  fetch request (byte PC)
//   rsp_valid_o/rsp_ready_i/rsp_inst_o/rsp_addr_o/rsp_err_o  response
//   flush_i  drop all responses accepted before this cycle
//   ld_en_i/ld_addr_i/ld_data_i/ld_be_i  program-load write
module inst_mem_pipe
   import inst_mem_pkg::*;
#(
   parameter int unsigned     XLEN           = 32,
   parameter int unsigned     MEM_SIZE_IN_KB = 4,
   parameter logic [XLEN-1:0] BASE_ADDR      = 32'h0000_0000,
   parameter string           INIT_FILE      = ""
) (
   input  logic            clk,
   input  logic            rst,
   inst_mem_pipe_if.slave  bus
);

   localparam int unsigned DEPTH = MEM_SIZE_IN_KB * 1024 / 4;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned CNT_W = 2;

   logic [XLEN-1:0]  mem [DEPTH];

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             pop;
   logic [XLEN-1:0]  req_off, req_idx;
   logic             req_mis, req_oor;
   logic [XLEN-1:0]  ld_off, ld_idx;
   logic             ld_hit;
   fetch_rsp_t       push_rsp;
   fetch_rsp_t       head;
   logic             fifo_full, fifo_empty;

   // Credit check only: no path from rsp_ready_i or req_valid_i
   assign bus.req_ready_o = !rst && !bus.ld_en_i && (cnt_q < CNT_W'(2));
   assign accept          = bus.req_valid_i && bus.req_ready_o;
   assign pop             = !fifo_empty && bus.rsp_ready_i;

   // Fetch decode; the array read lands in the response buffer at the edge
   always_comb begin
      push_rsp = '0;
      req_off  = bus.req_addr_i - BASE_ADDR;
      req_idx  = req_off >> 2;
      req_mis  = (bus.req_addr_i[1:0] != 2'b00);
      req_oor  = (bus.req_addr_i < BASE_ADDR) || (req_idx >= XLEN'(DEPTH));
      push_rsp.addr                = FETCH_W'(bus.req_addr_i);
      push_rsp.err[ERR_MISALIGNED] = req_mis;
      push_rsp.err[ERR_OOR]        = req_oor;
      if (req_mis || req_oor) begin
         push_rsp.inst = NOP_INST;
      end else begin
         push_rsp.inst = FETCH_W'(mem[req_idx[AW-1:0]]);
      end
   end

   // Load decode; low address bits fall away in the word index
   always_comb begin
      ld_off = bus.ld_addr_i - BASE_ADDR;
      ld_idx = ld_off >> 2;
      ld_hit = bus.ld_en_i && (bus.ld_addr_i >= BASE_ADDR) && (ld_idx < XLEN'(DEPTH));
   end

   // Byte-enabled program load; contents survive reset
   always_ff @(posedge clk) begin
      if (ld_hit) begin
         for (int b = 0; b < BE_W; b++) begin
            if (bus.ld_be_i[b]) begin
               mem[ld_idx[AW-1:0]][8*b +: 8] <= bus.ld_data_i[8*b +: 8];
            end
         end
      end
   end

   // Credits: a flush leaves only this cycle's accepted request outstanding
   always_comb begin
      cnt_d = cnt_q;
      if (bus.flush_i) begin
         cnt_d = CNT_W'(accept);
      end else begin
         cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   inst_rsp_fifo u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .din   (push_rsp),
      .pop   (pop),
      .flush (bus.flush_i),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.rsp_valid_o = !fifo_empty;
   assign bus.rsp_inst_o  = XLEN'(head.inst);
   assign bus.rsp_addr_o  = XLEN'(head.addr);
   assign bus.rsp_err_o   = head.err;

   // Credit counter and buffer occupancy must agree
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(accept && fifo_full));
   a_cnt_match:   assert property (@(posedge clk) disable iff (rst) fifo_empty == (cnt_q == '0));

endmodule

// File: tb/tb_inst_mem_pipe.sv
module tb_inst_mem_pipe;

   localparam longint      DEPTH1 = 1024;
   localparam logic [31:0] BASE1  = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] addr;
      logic [1:0]  err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   inst_mem_pipe_if #(.XLEN(32)) bus  ();
   inst_mem_pipe_if #(.XLEN(32)) bus2 ();

   inst_mem_pipe #(.XLEN(32), .MEM_SIZE_IN_KB(4), .BASE_ADDR(32'h0000_0000), .INIT_FILE("")) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   inst_mem_pipe #(.XLEN(32), .MEM_SIZE_IN_KB(1), .BASE_ADDR(32'h0000_0100), .INIT_FILE("")) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_pass  = 0;
   bit          mon_en  = 1'b0;
   exp_t        exp_q[$];
   logic [31:0] mm [1024];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   // Reference model: word-addressed array and fault rules from plain arithmetic
   function automatic void model_load(input logic [31:0] la, input logic [31:0] d, input logic [3:0] be);
      longint off;
      off = longint'(la) - longint'(BASE1);
      if (off < 0 || off / 4 >= DEPTH1) return;
      for (int b = 0; b < 4; b++)
         if (be[b]) mm[off / 4][8*b +: 8] = d[8*b +: 8];
   endfunction

   function automatic exp_t model_fetch(input logic [31:0] a);
      exp_t   e;
      longint off;
      off      = longint'(a) - longint'(BASE1);
      e.addr   = a;
      e.err[0] = (a % 4) != 0;
      e.err[1] = (off < 0) || (off / 4 >= DEPTH1);
      if (e.err != 2'b00) e.inst = NOP;
      else                e.inst = mm[off / 4];
      return e;
   endfunction

   // Monitor: compares the presented head against the scoreboard every cycle
   initial begin
      exp_t h;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_q.size() != 0));
            if (bus.rsp_valid_o === 1'b1 && exp_q.size() != 0) begin
               chk("rsp_inst", 64'(bus.rsp_inst_o), 64'(exp_q[0].inst));
               chk("rsp_addr", 64'(bus.rsp_addr_o), 64'(exp_q[0].addr));
               chk("rsp_err",  64'(bus.rsp_err_o),  64'(exp_q[0].err));
               if (bus.rsp_ready_i && !rst) h = exp_q.pop_front();
            end
         end
      end
   end

   // One clock of stimulus on the main DUT; scoreboard updated after the pop
   task automatic step(input bit v, input logic [31:0] a, input bit rr, input bit fl,
                       input bit le, input logic [31:0] la, input logic [31:0] ld,
                       input logic [3:0] be, input bit r);
      bit er;
      @(posedge clk); #1;
      rst             = r;
      bus.req_valid_i = v;
      bus.req_addr_i  = a;
      bus.rsp_ready_i = rr;
      bus.flush_i     = fl;
      bus.ld_en_i     = le;
      bus.ld_addr_i   = la;
      bus.ld_data_i   = ld;
      bus.ld_be_i     = be;
      #1;
      er = !r && !le && (exp_q.size() < 2);
      chk("req_ready", 64'(bus.req_ready_o), 64'(er));
      @(negedge clk); #1;
      if (r) exp_q.delete();
      else begin
         if (le) model_load(la, ld, be);
         if (fl) exp_q.delete();
         if (v && er) exp_q.push_back(model_fetch(a));
      end
   endtask

   task automatic fetch(input logic [31:0] a, input bit rr, input bit fl);
      step(1'b1, a, rr, fl, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
   endtask

   task automatic idle(input bit rr);
      step(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
   endtask

   task automatic load(input logic [31:0] la, input logic [31:0] d, input logic [3:0] be);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, la, d, be, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      @(posedge clk); #2;
      chk("reset_valid", 64'(bus.rsp_valid_o), 64'(0));
      chk("reset_inst",  64'(bus.rsp_inst_o),  64'(0));
      chk("reset_addr",  64'(bus.rsp_addr_o),  64'(0));
      chk("reset_err",   64'(bus.rsp_err_o),   64'(0));
   endtask

   // Directed checks on the BASE_ADDR=0x100, 256-word instance
   task automatic d2_load(input logic [31:0] la, input logic [31:0] d);
      @(posedge clk); #1;
      bus2.ld_en_i = 1'b1; bus2.ld_addr_i = la; bus2.ld_data_i = d; bus2.ld_be_i = 4'hF;
      #1 chk("d2_ready_during_load", 64'(bus2.req_ready_o), 64'(0));
      @(posedge clk); #1;
      bus2.ld_en_i = 1'b0;
   endtask

   task automatic d2_fetch(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ee);
      @(posedge clk); #1;
      bus2.req_valid_i = 1'b1; bus2.req_addr_i = a; bus2.rsp_ready_i = 1'b1;
      #1 chk("d2_req_ready", 64'(bus2.req_ready_o), 64'(1));
      @(posedge clk); #1;
      bus2.req_valid_i = 1'b0;
      #1;
      chk("d2_rsp_valid", 64'(bus2.rsp_valid_o), 64'(1));
      chk("d2_rsp_inst",  64'(bus2.rsp_inst_o),  64'(ei));
      chk("d2_rsp_addr",  64'(bus2.rsp_addr_o),  64'(a));
      chk("d2_rsp_err",   64'(bus2.rsp_err_o),   64'(ee));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid_i  = 0; bus.req_addr_i  = 0; bus.rsp_ready_i  = 0; bus.flush_i  = 0;
      bus.ld_en_i      = 0; bus.ld_addr_i   = 0; bus.ld_data_i    = 0; bus.ld_be_i  = 0;
      bus2.req_valid_i = 0; bus2.req_addr_i = 0; bus2.rsp_ready_i = 0; bus2.flush_i = 0;
      bus2.ld_en_i     = 0; bus2.ld_addr_i  = 0; bus2.ld_data_i   = 0; bus2.ld_be_i = 0;

      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      do_reset();
      mon_en = 1'b1;

      // Program image: random words, then the known head of the program
      for (int w = 0; w < 1024; w++) load(32'(w * 4), $urandom, 4'hF);
      load(32'h0, 32'h11, 4'hF);
      load(32'h4, 32'h22, 4'hF);
      load(32'h8, 32'h33, 4'hF);
      load(32'hC, 32'h44, 4'hF);

      // Streaming at one per cycle
      fetch(32'h0, 1'b1, 1'b0);
      fetch(32'h4, 1'b1, 1'b0);
      fetch(32'h8, 1'b1, 1'b0);
      fetch(32'hC, 1'b1, 1'b0);
      idle(1'b1); idle(1'b1);

      // Backpressure: third request refused until a slot frees
      fetch(32'h10, 1'b0, 1'b0);
      fetch(32'h14, 1'b0, 1'b0);
      fetch(32'h18, 1'b0, 1'b0);
      idle(1'b0); idle(1'b0);
      fetch(32'h18, 1'b1, 1'b0);
      fetch(32'h18, 1'b1, 1'b0);
      idle(1'b1); idle(1'b1); idle(1'b1);

      // Faults, including last valid word and first word past the end
      fetch(32'h2, 1'b1, 1'b0);
      fetch(32'h1000, 1'b1, 1'b0);
      fetch(32'hFFC, 1'b1, 1'b0);
      fetch(32'h1003, 1'b1, 1'b0);
      fetch(32'hFFFF_FFFC, 1'b1, 1'b0);
      idle(1'b1); idle(1'b1);

      // Partial byte load over 0x33
      load(32'h8, 32'hAABB_CCDD, 4'b0101);
      fetch(32'h8, 1'b1, 1'b0);
      idle(1'b1); idle(1'b1);

      // Flush with two buffered (request refused), then flush with a survivor
      fetch(32'h0, 1'b0, 1'b0);
      fetch(32'h4, 1'b0, 1'b0);
      fetch(32'h20, 1'b0, 1'b1);
      idle(1'b0);
      fetch(32'h0, 1'b0, 1'b0);
      fetch(32'h20, 1'b0, 1'b1);
      idle(1'b0); idle(1'b1); idle(1'b1);

      // Reset with two responses buffered
      fetch(32'h0, 1'b0, 1'b0);
      fetch(32'h4, 1'b0, 1'b0);
      idle(1'b0);
      do_reset();
      idle(1'b1);

      // Randomised traffic
      for (int i = 0; i < 2500; i++) begin
         bit          v, rr, fl, le, r;
         logic [31:0] a, la, ld;
         logic [3:0]  be;
         v  = $urandom_range(0, 9) < 7;
         rr = $urandom_range(0, 9) < 6;
         fl = $urandom_range(0, 19) == 0;
         r  = $urandom_range(0, 149) == 0;
         le = !r && ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 9) < 8) a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
         else                          a = $urandom;
         if ($urandom_range(0, 9) < 8) la = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
         else                          la = $urandom;
         ld = $urandom;
         be = 4'($urandom_range(0, 15));
         step(v, a, rr, fl, le, la, ld, be, r);
      end
      idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b1);

      // Non-zero base instance
      d2_load(32'h100, 32'hCAFE_0001);
      d2_load(32'h4FC, 32'h5A5A_1234);
      d2_load(32'h500, 32'hDEAD_BEEF);
      d2_fetch(32'hFC,  NOP, 2'b10);
      d2_fetch(32'h100, 32'hCAFE_0001, 2'b00);
      d2_fetch(32'h4FC, 32'h5A5A_1234, 2'b00);
      d2_fetch(32'h500, NOP, 2'b10);
      d2_fetch(32'h102, NOP, 2'b01);
      d2_fetch(32'h503, NOP, 2'b11);
      d2_fetch(32'h0,   NOP, 2'b10);

      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
